// File: rtl/regfile_sb_if.sv
// Register-file bus: decode-side read/issue ports and writeback port.
// The master modport is the pipeline side, the slave modport is the register file.
interface regfile_sb_if #(
   parameter int DW = 32,
   parameter int AW = 5
);
   logic [AW-1:0] rna;
   logic [AW-1:0] rnb;
   logic [DW-1:0] qa;
   logic [DW-1:0] qb;
   logic          busya;
   logic          busyb;
   logic          we;
   logic [AW-1:0] wn;
   logic [DW-1:0] d;
   logic          iss;
   logic [AW-1:0] isn;
   logic [AW:0]   pend_cnt;
   logic          init_done;

   modport master (
      output rna, rnb, we, wn, d, iss, isn,
      input  qa, qb, busya, busyb, pend_cnt, init_done
   );

   modport slave (
      input  rna, rnb, we, wn, d, iss, isn,
      output qa, qb, busya, busyb, pend_cnt, init_done
   );
endinterface

// File: rtl/regfile_sb.sv
// Two-read-port register file with write-to-read bypass, optional hardwired
// zero register and a pending-write scoreboard. Storage carries no reset; a
// sweep state machine zeroes every entry after clr so it can map onto RAM.
module regfile_sb #(
   parameter int DW       = 32,
   parameter int AW       = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input logic         clk,
   input logic         clr,
   regfile_sb_if.slave bus
);
   localparam int DEPTH = 2**AW;

   typedef enum logic {INIT, RUN} state_t;

   state_t           state;
   state_t           statenext;
   logic [AW-1:0]    sweep;
   logic [DW-1:0]    mem [DEPTH];
   logic [DEPTH-1:0] pend;
   logic [DEPTH-1:0] pendnext;
   logic [AW:0]      pendcnt;
   logic             running;
   logic             wrclr;
   logic             wrmem;
   logic             issset;
   logic             issrise;
   logic             wrfall;
   logic             hita;
   logic             hitb;

   // State register; clr always restarts the zeroing sweep.
   always_ff @(posedge clk) begin
      if (clr) state <= INIT;
      else     state <= statenext;
   end

   // Sweep pointer walks every entry once while in INIT.
   always_ff @(posedge clk) begin
      if (clr)                sweep <= '0;
      else if (state == INIT) sweep <= sweep + AW'(1);
   end

   // Leave INIT right after the last entry has been zeroed.
   always_comb begin
      statenext = state;
      running   = 1'b0;
      case (state)
         INIT:    if (&sweep) statenext = RUN;
         RUN:     running = 1'b1;
         default: statenext = INIT;
      endcase
   end

   assign bus.init_done = running;

   // Qualify writeback and issue, and work out the next scoreboard and its count delta.
   always_comb begin
      wrclr    = running & bus.we;
      wrmem    = wrclr & ~(ZERO_REG & (bus.wn == '0));
      issset   = running & bus.iss & ~(ZERO_REG & (bus.isn == '0));
      issrise  = issset & ~pend[bus.isn];
      wrfall   = wrclr & pend[bus.wn] & ~(issset & (bus.isn == bus.wn));
      pendnext = pend;
      if (wrclr)  pendnext[bus.wn]  = 1'b0;
      if (issset) pendnext[bus.isn] = 1'b1;
   end

   // Storage has no reset of its own: the sweep zeroes it, then writeback fills it.
   always_ff @(posedge clk) begin
      if (!clr) begin
         if (state == INIT) mem[sweep]  <= '0;
         else if (wrmem)    mem[bus.wn] <= bus.d;
      end
   end

   // Scoreboard bits plus a running count that only moves on real bit transitions.
   always_ff @(posedge clk) begin
      if (clr) begin
         pend    <= '0;
         pendcnt <= '0;
      end else begin
         pend    <= pendnext;
         pendcnt <= pendcnt + (AW+1)'(issrise) - (AW+1)'(wrfall);
      end
   end

   assign bus.pend_cnt = pendcnt;

   // Combinational read ports: zero register first, then bypass, then storage.
   always_comb begin
      hita      = BYPASS & wrclr & (bus.wn == bus.rna);
      hitb      = BYPASS & wrclr & (bus.wn == bus.rnb);
      bus.qa    = '0;
      bus.qb    = '0;
      bus.busya = 1'b0;
      bus.busyb = 1'b0;
      if (running && !(ZERO_REG && (bus.rna == '0))) begin
         bus.qa    = hita ? bus.d : mem[bus.rna];
         bus.busya = pend[bus.rna] & ~hita;
      end
      if (running && !(ZERO_REG && (bus.rnb == '0))) begin
         bus.qb    = hitb ? bus.d : mem[bus.rnb];
         bus.busyb = pend[bus.rnb] & ~hitb;
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus a random phase,
// checked through a scoreboard fed by a small behavioural model.
module tb_regfile_sb;
   localparam int DW    = 32;
   localparam int AW    = 5;
   localparam int DEPTH = 32;

   logic clk = 1'b0;
   logic clr;

   always #5 clk = ~clk;

   regfile_sb_if #(.DW(DW), .AW(AW)) bus ();

   regfile_sb #(.DW(DW), .AW(AW), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus.slave)
   );

   typedef enum int {SEL_QA, SEL_QB, SEL_BUSYA, SEL_BUSYB, SEL_PCNT, SEL_INIT} sel_t;
   typedef struct {
      string       tag;
      sel_t        sel;
      logic [31:0] exp;
   } item_t;

   item_t nowQ[$];
   item_t nextQ[$];
   int    compared   = 0;
   int    mismatched = 0;

   logic [DW-1:0]    shadow [DEPTH];
   logic [DEPTH-1:0] pendM;
   int               initLeft;

   // Single comparison point for every check in the bench.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Pick the DUT output a scoreboard entry refers to.
   function automatic logic [31:0] observe(input sel_t sel);
      case (sel)
         SEL_QA:    return bus.qa;
         SEL_QB:    return bus.qb;
         SEL_BUSYA: return {31'b0, bus.busya};
         SEL_BUSYB: return {31'b0, bus.busyb};
         SEL_PCNT:  return {26'b0, bus.pend_cnt};
         default:   return {31'b0, bus.init_done};
      endcase
   endfunction

   function automatic logic [31:0] popM();
      int n = 0;
      for (int k = 0; k < DEPTH; k++) if (pendM[k]) n++;
      return 32'(n);
   endfunction

   // Expected read data from the model state before the coming edge.
   function automatic logic [31:0] modelRead(input logic [AW-1:0] ra, input logic w,
                                             input logic [AW-1:0] n, input logic [DW-1:0] data);
      if (initLeft != 0) return '0;
      if (ra == 0) return '0;
      if (w && n == ra) return data;
      return shadow[ra];
   endfunction

   function automatic logic [31:0] modelBusy(input logic [AW-1:0] ra, input logic w,
                                             input logic [AW-1:0] n);
      if (initLeft != 0 || ra == 0) return '0;
      return {31'b0, pendM[ra] && !(w && n == ra)};
   endfunction

   task automatic expectNow(input string tag, input sel_t sel, input logic [31:0] v);
      nowQ.push_back('{tag, sel, v});
   endtask

   task automatic expectNext(input string tag, input sel_t sel, input logic [31:0] v);
      nextQ.push_back('{tag, sel, v});
   endtask

   // Drive one cycle at the falling edge, check combinational outputs mid-cycle,
   // check registered outputs after the rising edge, then advance the model.
   task automatic applyStimulus(input logic c, input logic w, input logic [AW-1:0] n,
                                input logic [DW-1:0] data, input logic i, input logic [AW-1:0] isnv,
                                input logic [AW-1:0] ra, input logic [AW-1:0] rb, input string tag);
      item_t it;
      clr     = c;
      bus.we  = w;
      bus.wn  = n;
      bus.d   = data;
      bus.iss = i;
      bus.isn = isnv;
      bus.rna = ra;
      bus.rnb = rb;
      expectNow({tag, " qa"},    SEL_QA,    modelRead(ra, w, n, data));
      expectNow({tag, " qb"},    SEL_QB,    modelRead(rb, w, n, data));
      expectNow({tag, " busya"}, SEL_BUSYA, modelBusy(ra, w, n));
      expectNow({tag, " busyb"}, SEL_BUSYB, modelBusy(rb, w, n));
      expectNow({tag, " init"},  SEL_INIT,  {31'b0, initLeft == 0});
      expectNow({tag, " pcnt"},  SEL_PCNT,  popM());
      #2;
      while (nowQ.size() > 0) begin
         it = nowQ.pop_front();
         checkOutput(it.tag, observe(it.sel), it.exp);
      end
      @(posedge clk);
      #1;
      while (nextQ.size() > 0) begin
         it = nextQ.pop_front();
         checkOutput(it.tag, observe(it.sel), it.exp);
      end
      if (c) begin
         initLeft = DEPTH;
         pendM    = '0;
         for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
      end else if (initLeft != 0) begin
         initLeft--;
      end else begin
         if (w && n != 0) shadow[n] = data;
         if (w) pendM[n] = 1'b0;
         if (i && isnv != 0) pendM[isnv] = 1'b1;
      end
      @(negedge clk);
   endtask

   // Hard stop in case something stalls the stimulus thread.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, random traffic, then reset during the sweep.
   initial begin
      int n;
      clr     = 1'b1;
      bus.we  = 1'b0;
      bus.wn  = '0;
      bus.d   = '0;
      bus.iss = 1'b0;
      bus.isn = '0;
      bus.rna = '0;
      bus.rnb = '0;
      initLeft = DEPTH;
      pendM    = '0;
      for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
      @(negedge clk);

      // Sweep: traffic during INIT must be ignored, init_done low for 32 cycles.
      for (int k = 0; k < DEPTH; k++) begin
         expectNow("t1 init low", SEL_INIT, 32'd0);
         applyStimulus(1'b0, 1'b1, (k == 0) ? AW'(1) : AW'(k - 1), $urandom, 1'b1,
                       AW'(k | 1), AW'(k), AW'(DEPTH - 1 - k), "t1 sweep");
      end
      for (int k = 0; k < DEPTH; k++) begin
         expectNow("t1 init high", SEL_INIT, 32'd1);
         expectNow("t1 read zero", SEL_QA, 32'd0);
         expectNow("t1 pcnt zero", SEL_PCNT, 32'd0);
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(k), AW'(k), "t1 read");
      end

      // Bypass on the write cycle, stored value afterwards.
      expectNow("t2 bypass qa", SEL_QA, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd5, "t2 write");
      expectNow("t2 stored qa", SEL_QA, 32'hDEADBEEF);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd0, "t2 read");

      // Register 0 ignores writes and issues.
      expectNow("t3 zero bypass", SEL_QA, 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, '0, 5'd0, 5'd0, "t3 write0");
      expectNow("t3 read0", SEL_QA, 32'd0);
      expectNext("t3 pcnt iss0", SEL_PCNT, 32'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd0, "t3 iss0");
      expectNow("t3 busy0", SEL_BUSYA, 32'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd0, "t3 idle");

      // Issue, re-issue, writeback clears busy in the same cycle.
      expectNext("t4 pcnt iss", SEL_PCNT, 32'd1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0, "t4 iss7");
      expectNow("t4 busya", SEL_BUSYA, 32'd1);
      expectNext("t4 pcnt reiss", SEL_PCNT, 32'd1);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 5'd0, "t4 reiss7");
      expectNow("t4 busya wb", SEL_BUSYA, 32'd0);
      expectNow("t4 qa wb", SEL_QA, 32'h00007777);
      expectNext("t4 pcnt wb", SEL_PCNT, 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd7, 32'h00007777, 1'b0, '0, 5'd7, 5'd7, "t4 wb7");
      expectNow("t4 busya idle", SEL_BUSYA, 32'd0);
      expectNext("t4 pcnt nonpending wb", SEL_PCNT, 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, '0, 5'd7, 5'd9, "t4 wb9");

      // Issue and writeback to the same register: issue wins, data lands.
      expectNext("t5 pcnt", SEL_PCNT, 32'd1);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFE0003, 1'b1, 5'd3, 5'd3, 5'd3, "t5 iss+wb3");
      expectNow("t5 busya", SEL_BUSYA, 32'd1);
      expectNow("t5 qa", SEL_QA, 32'hCAFE0003);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd3, "t5 read3");
      expectNext("t5 pcnt clear", SEL_PCNT, 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFE0003, 1'b0, '0, 5'd3, 5'd4, "t5 wb3");

      // Random traffic concentrated on a few registers to exercise hazards.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(1'b0, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 9) < 4), AW'($urandom_range(0, 7)),
                       AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), "rnd");
      end

      // Reset from RUN, then reset again ten cycles into the sweep.
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd5, "t6 clr");
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(k), 5'd3, "t6 sweep a");
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd5, "t6 clr again");
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (bus.init_done) break;
         n++;
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(k), 5'd3, "t6 sweep b");
      end
      checkOutput("t6 sweep length", 32'(n), 32'd32);
      expectNow("t6 pcnt", SEL_PCNT, 32'd0);
      expectNow("t6 qa3 cleared", SEL_QA, 32'd0);
      expectNow("t6 qb5 cleared", SEL_QB, 32'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd5, "t6 read");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
